core_acc_quant: RTL and testbench

Downstream stage of the MAC core. It consumes the signed dot-product partial sums emitted by the MAC/adder-tree pipeline and accumulates a configurable number of them into one wide sum. It then rounds, right-shifts and saturates each sum to an int8 result and presents it on a valid/ready output. The MAC pipeline has no backpressure, so this block holds completed results in a 2-entry output buffer and flags any result lost to overrun.

---
 rtl/core_pkg.sv | 11 +
 rtl/core_acc_quant_if.sv | 23 ++
 rtl/acc_out_fifo.sv | 38 +++
 rtl/core_acc_quant.sv | 99 +++++++++
 tb/tb_core_acc_quant.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared FSM state type, default widths and int8 saturation bounds for the accumulate/quantize stage
package core_pkg;
  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_e;
  localparam int IDATA_BIT = 20;
  localparam int CNT_BIT = 16;
  localparam int ACC_BIT = IDATA_BIT + CNT_BIT;
  localparam int ODATA_BIT = 8;
  localparam int SHIFT_BIT = 5;
  localparam int SAT_MAX = 2 ** (ODATA_BIT - 1) - 1;
  localparam int SAT_MIN = -(2 ** (ODATA_BIT - 1));
endpackage

// File: rtl/core_acc_quant_if.sv
// core_acc_quant_if: configuration, partial-sum input and valid/ready result bus of the accumulate/quantize stage
//   master drives cfg_acc_num, cfg_shift, idata, idata_valid, odata_ready
//   slave drives odata, odata_valid, acc_busy, sat_flag, err_drop
interface core_acc_quant_if import core_pkg::*; ();
  logic [CNT_BIT-1:0] cfg_acc_num;
  logic [SHIFT_BIT-1:0] cfg_shift;
  logic [IDATA_BIT-1:0] idata;
  logic idata_valid;
  logic [ODATA_BIT-1:0] odata;
  logic odata_valid;
  logic odata_ready;
  logic acc_busy;
  logic sat_flag;
  logic err_drop;
  modport master (
    output cfg_acc_num, cfg_shift, idata, idata_valid, odata_ready,
    input odata, odata_valid, acc_busy, sat_flag, err_drop
  );
  modport slave (
    input cfg_acc_num, cfg_shift, idata, idata_valid, odata_ready,
    output odata, odata_valid, acc_busy, sat_flag, err_drop
  );
endinterface

// File: rtl/acc_out_fifo.sv
// acc_out_fifo: 2-deep synchronous FIFO with full/empty flags; a push into a full FIFO succeeds when a pop happens in the same cycle
//   clk, rstn (async active-low), push_i/wdata_i write side, pop_i read side, rdata_o head entry, full_o, empty_o
module acc_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic wp_q, rp_q, wr, rd;
  logic [1:0] cnt_q;
  assign empty_o = cnt_q == 2'd0;
  assign full_o = cnt_q == 2'd2;
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  assign rdata_o = mem_q[rp_q];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= wdata_i;
        wp_q <= ~wp_q;
      end
      if (rd) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, wr} - {1'b0, rd};
    end
endmodule

// File: rtl/core_acc_quant.sv
// core_acc_quant: accumulates N signed partial sums per group, rounds/shifts/saturates each sum to int8 and buffers results for a valid/ready consumer
//   clk, rstn (async active-low); bus (slave) carries cfg_acc_num, cfg_shift, idata/idata_valid,
//   odata/odata_valid/odata_ready and the status outputs acc_busy, sat_flag, err_drop
module core_acc_quant import core_pkg::*; (
  input logic clk,
  input logic rstn,
  core_acc_quant_if.slave bus
);
  localparam logic signed [ACC_BIT:0] HI = (ACC_BIT + 1)'(SAT_MAX);
  localparam logic signed [ACC_BIT:0] LO = (ACC_BIT + 1)'(SAT_MIN);
  acc_state_e state_q, state_d;
  logic [CNT_BIT-1:0] n_q, n_d, cnt_q, cnt_d, cfg_n;
  logic [SHIFT_BIT-1:0] s_q, s_d, fin_s_q, fin_s_d;
  logic [ACC_BIT-1:0] acc_q, acc_d, fin_sum_q, fin_sum_d, sum_in, acc_nx;
  logic fin_valid_q, fin_valid_d, sat_q, sat_d, drop_q, drop_d;
  logic [ACC_BIT:0] half;
  logic signed [ACC_BIT:0] rnd, shr;
  logic clamp_hi, clamp_lo, full, empty, pop;
  logic [ODATA_BIT-1:0] qdata, head;
  assign sum_in = {{(ACC_BIT - IDATA_BIT){bus.idata[IDATA_BIT-1]}}, bus.idata};
  assign acc_nx = acc_q + sum_in;
  assign cfg_n = (bus.cfg_acc_num == '0) ? CNT_BIT'(1) : bus.cfg_acc_num;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    s_d = s_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    fin_sum_d = fin_sum_q;
    fin_s_d = fin_s_q;
    fin_valid_d = 1'b0;
    if (bus.idata_valid && state_q == ACC_IDLE) begin
      n_d = cfg_n;
      s_d = bus.cfg_shift;
      cnt_d = CNT_BIT'(1);
      acc_d = sum_in;
      fin_valid_d = cfg_n == CNT_BIT'(1);
      fin_sum_d = sum_in;
      fin_s_d = bus.cfg_shift;
      state_d = fin_valid_d ? ACC_IDLE : ACC_RUN;
    end else if (bus.idata_valid) begin
      cnt_d = cnt_q + CNT_BIT'(1);
      acc_d = acc_nx;
      fin_valid_d = cnt_d == n_q;
      fin_sum_d = acc_nx;
      fin_s_d = s_q;
      state_d = fin_valid_d ? ACC_IDLE : ACC_RUN;
    end
  end
  // One extra bit of headroom so adding the rounding half never wraps.
  assign half = (fin_s_q == '0) ? '0 : (ACC_BIT + 1)'(1) << (fin_s_q - 1'b1);
  assign rnd = {fin_sum_q[ACC_BIT-1], fin_sum_q} + half;
  assign shr = rnd >>> fin_s_q;
  assign clamp_hi = shr > HI;
  assign clamp_lo = shr < LO;
  assign qdata = clamp_hi ? ODATA_BIT'(SAT_MAX) : clamp_lo ? ODATA_BIT'(SAT_MIN) : shr[ODATA_BIT-1:0];
  assign pop = !empty && bus.odata_ready;
  assign sat_d = sat_q | (fin_valid_q & (clamp_hi | clamp_lo));
  assign drop_d = drop_q | (fin_valid_q & full & ~pop);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ACC_IDLE;
      n_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      fin_sum_q <= '0;
      fin_s_q <= '0;
      fin_valid_q <= 1'b0;
      sat_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      fin_sum_q <= fin_sum_d;
      fin_s_q <= fin_s_d;
      fin_valid_q <= fin_valid_d;
      sat_q <= sat_d;
      drop_q <= drop_d;
    end
  acc_out_fifo #(.W(ODATA_BIT)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push_i(fin_valid_q),
    .wdata_i(qdata),
    .pop_i(pop),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  assign bus.odata = head;
  assign bus.odata_valid = !empty;
  assign bus.acc_busy = state_q == ACC_RUN;
  assign bus.sat_flag = sat_q;
  assign bus.err_drop = drop_q;
endmodule

// File: tb/tb_core_acc_quant.sv
// tb_core_acc_quant: directed and randomized checks of core_acc_quant against a group/queue reference model
module tb_core_acc_quant;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;
  core_acc_quant_if bus();
  core_acc_quant dut(.clk(clk), .rstn(rstn), .bus(bus));
  int checks = 0;
  int failures = 0;
  bit in_grp, fin_v, fin_c, exp_sat, exp_drop;
  int m_n, m_s, m_cnt, fin_val;
  longint m_sum;
  int fq[$];
  int got[$];

  function automatic int quant(input longint s, input int sh, output bit c);
    longint r;
    r = (sh == 0) ? s : ((s + (longint'(1) << (sh - 1))) >>> sh);
    c = (r > 127) || (r < -128);
    return (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
  endfunction

  task automatic model_reset();
    in_grp = 1'b0;
    fin_v = 1'b0;
    exp_sat = 1'b0;
    exp_drop = 1'b0;
    fq.delete();
    got.delete();
  endtask

  // Drive one cycle, advance the reference model across the clock edge, return at edge+1.
  task automatic tick(input bit v, input int d, input bit r);
    bus.idata_valid = v;
    bus.idata = IDATA_BIT'(d);
    bus.odata_ready = r;
    if (bus.odata_valid === 1'b1 && r) got.push_back(int'($signed(bus.odata)));
    if (fq.size() > 0 && r) void'(fq.pop_front());
    if (fin_v) begin
      if (fq.size() < 2) fq.push_back(fin_val);
      else exp_drop = 1'b1;
      if (fin_c) exp_sat = 1'b1;
    end
    fin_v = 1'b0;
    if (v) begin
      if (!in_grp) begin
        m_n = (bus.cfg_acc_num == 0) ? 1 : int'(bus.cfg_acc_num);
        m_s = int'(bus.cfg_shift);
        m_sum = d;
        m_cnt = 1;
      end else begin
        m_sum += d;
        m_cnt++;
      end
      in_grp = m_cnt < m_n;
      if (!in_grp) begin
        fin_val = quant(m_sum, m_s, fin_c);
        fin_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.cfg_acc_num = '0;
    bus.cfg_shift = '0;
    bus.idata = '0;
    bus.idata_valid = 1'b0;
    bus.odata_ready = 1'b0;
    #3;
    checks++; if (bus.odata !== 8'd0) begin failures++; $display("FAIL rst_odata got=%0d exp=0", bus.odata); end
    checks++; if (bus.odata_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.odata_valid); end
    checks++; if (bus.acc_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.acc_busy); end
    checks++; if (bus.sat_flag !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", bus.sat_flag); end
    checks++; if (bus.err_drop !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b exp=0", bus.err_drop); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_group4();
    bus.cfg_acc_num = 16'd4;
    bus.cfg_shift = 5'd0;
    got.delete();
    tick(1, 10, 1);
    checks++; if (bus.acc_busy !== 1'b1) begin failures++; $display("FAIL g4_busy_first got=%b exp=1", bus.acc_busy); end
    tick(1, 20, 1);
    tick(1, 30, 1);
    checks++; if (bus.acc_busy !== 1'b1) begin failures++; $display("FAIL g4_busy_mid got=%b exp=1", bus.acc_busy); end
    tick(1, 40, 1);
    checks++; if (bus.acc_busy !== 1'b0) begin failures++; $display("FAIL g4_busy_end got=%b exp=0", bus.acc_busy); end
    checks++; if (bus.odata_valid !== 1'b0) begin failures++; $display("FAIL g4_valid_t1 got=%b exp=0", bus.odata_valid); end
    tick(0, 0, 1);
    checks++; if (bus.odata_valid !== 1'b1) begin failures++; $display("FAIL g4_valid_t2 got=%b exp=1", bus.odata_valid); end
    checks++; if ($signed(bus.odata) !== 100) begin failures++; $display("FAIL g4_data got=%0d exp=100", $signed(bus.odata)); end
    tick(0, 0, 1);
    checks++; if (got.size() != 1 || bus.odata_valid !== 1'b0) begin failures++; $display("FAIL g4_single got_n=%0d valid=%b exp_n=1 valid=0", got.size(), bus.odata_valid); end
  endtask

  task automatic test_round();
    int exp_q[3] = '{2, -1, 1};
    bus.cfg_acc_num = 16'd1;
    bus.cfg_shift = 5'd2;
    tick(1, 6, 1);
    tick(1, -6, 1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.odata_valid !== 1'b1 || $signed(bus.odata) !== exp_q[i]) begin failures++; $display("FAIL round_%0d got=%0d valid=%b exp=%0d", i, $signed(bus.odata), bus.odata_valid, exp_q[i]); end
      tick(i == 0, 5, 1);
    end
    checks++; if (bus.odata_valid !== 1'b0) begin failures++; $display("FAIL round_drain got=%b exp=0", bus.odata_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin failures++; $display("FAIL round_sat got=%b exp=0", bus.sat_flag); end
  endtask

  task automatic test_sat();
    bus.cfg_acc_num = 16'd2;
    bus.cfg_shift = 5'd0;
    got.delete();
    tick(1, 100, 1);
    tick(1, 100, 1);
    tick(1, -200, 1);
    tick(1, -1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    checks++; if (got.size() != 2 || got[0] != 127 || got[1] != -128) begin failures++; $display("FAIL sat_values got=%p exp='{127,-128}", got); end
    checks++; if (bus.sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", bus.sat_flag); end
  endtask

  task automatic test_cfg_change();
    bus.cfg_acc_num = 16'd3;
    bus.cfg_shift = 5'd0;
    got.delete();
    tick(1, 5, 1);
    bus.cfg_acc_num = 16'd1;
    tick(1, 5, 1);
    tick(1, 5, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    checks++; if (got.size() != 1 || got[0] != 15) begin failures++; $display("FAIL cfg_hold got=%p exp='{15}", got); end
    tick(1, 7, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    checks++; if (got.size() != 2 || got[1] != 7) begin failures++; $display("FAIL cfg_next got=%p exp='{15,7}", got); end
  endtask

  task automatic test_overrun();
    bus.cfg_acc_num = 16'd1;
    bus.cfg_shift = 5'd0;
    got.delete();
    checks++; if (bus.err_drop !== 1'b0) begin failures++; $display("FAIL ovr_pre_drop got=%b exp=0", bus.err_drop); end
    tick(1, 1, 0);
    tick(1, 2, 0);
    tick(1, 3, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    checks++; if (bus.err_drop !== 1'b1) begin failures++; $display("FAIL ovr_drop got=%b exp=1", bus.err_drop); end
    checks++; if (bus.odata_valid !== 1'b1 || $signed(bus.odata) !== 1) begin failures++; $display("FAIL ovr_head got=%0d valid=%b exp=1", $signed(bus.odata), bus.odata_valid); end
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    checks++; if (got.size() != 2 || got[0] != 1 || got[1] != 2) begin failures++; $display("FAIL ovr_order got=%p exp='{1,2}", got); end
    checks++; if (bus.odata_valid !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", bus.odata_valid); end
  endtask

  task automatic test_reset_mid();
    bus.cfg_acc_num = 16'd4;
    bus.cfg_shift = 5'd0;
    tick(1, 9, 1);
    tick(1, 9, 1);
    bus.idata_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (bus.acc_busy !== 1'b0 || bus.odata_valid !== 1'b0 || bus.odata !== 8'd0) begin failures++; $display("FAIL rmid_out busy=%b valid=%b odata=%0d exp=0,0,0", bus.acc_busy, bus.odata_valid, bus.odata); end
    checks++; if (bus.sat_flag !== 1'b0 || bus.err_drop !== 1'b0) begin failures++; $display("FAIL rmid_flags sat=%b drop=%b exp=0,0", bus.sat_flag, bus.err_drop); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) tick(1, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    checks++; if (got.size() != 1 || got[0] != 4) begin failures++; $display("FAIL rmid_sum got=%p exp='{4}", got); end
  endtask

  task automatic test_random(input int cycles, input bit always_ready);
    int d;
    bit v, r;
    for (int i = 0; i < cycles; i++) begin
      bus.cfg_acc_num = 16'($urandom_range(0, 5));
      bus.cfg_shift = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1048575)) - 524288 : int'($urandom_range(0, 600)) - 300;
      v = $urandom_range(0, 9) < 7;
      r = always_ready || ($urandom_range(0, 9) < 5);
      tick(v, d, r);
      checks++; if (bus.odata_valid !== (fq.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.odata_valid, fq.size() > 0); end
      if (fq.size() > 0) begin
        checks++; if ($signed(bus.odata) !== fq[0]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", i, $signed(bus.odata), fq[0]); end
      end
      checks++; if (bus.acc_busy !== in_grp) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, bus.acc_busy, in_grp); end
      checks++; if (bus.sat_flag !== exp_sat) begin failures++; $display("FAIL rnd_sat cyc=%0d got=%b exp=%b", i, bus.sat_flag, exp_sat); end
      checks++; if (bus.err_drop !== exp_drop) begin failures++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", i, bus.err_drop, exp_drop); end
      if (always_ready) begin
        checks++; if (bus.err_drop !== 1'b0) begin failures++; $display("FAIL rdy_nodrop cyc=%0d got=%b exp=0", i, bus.err_drop); end
      end
    end
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_group4();
    test_round();
    test_sat();
    test_cfg_change();
    test_random(1500, 1'b1);
    test_overrun();
    test_reset_mid();
    test_random(3000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
